meas_text_serializer: RTL and testbench

- Sits directly downstream of the measurement function block.
- Snapshots the BCD measurement results (frequency, max, min, mean, RMS, Vp2p) at a rate-limited display interval, aligned to a period boundary.
- Serializes the snapshot into a fixed 67-character ASCII frame over a valid/ready byte stream, which feeds the UART / text-overlay stage.

---
 rtl/meas_text_serializer.sv | 189 ++++++++++++++++++
 tb/tb_meas_text_serializer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/meas_text_serializer.sv
// Snapshots the BCD measurement results at a rate-limited, period-aligned interval
// and streams them out as a fixed 67-character ASCII frame over a valid/ready byte port.
//
// state | meaning
// ------+-------------------------------------------------------------
// HOLD  | display hold-off; counter runs up to HOLD_CYCLES-1
// ARM   | hold-off elapsed and RUN high; waiting for PERIOD_FLAG rise
// LOAD  | capture all six measurements, pulse FRAME_START
// SEND  | present frame byte at idx, advance on each transfer
// DONE  | pulse FRAME_DONE, restart hold-off
module meas_text_serializer #(
  parameter int HOLD_CYCLES = 25000000,
  parameter int HOLD_W      = 25
) (
  input  logic        CLK,
  input  logic        RSTB,
  input  logic        RUN,
  input  logic        PERIOD_FLAG,
  input  logic [23:0] frequency,
  input  logic [19:0] max_t,
  input  logic [19:0] min_t,
  input  logic [19:0] mean_t,
  input  logic [19:0] mean_t2,
  input  logic [19:0] Vp2p_vol_t,
  output logic [7:0]  CHAR_DATA,
  output logic        CHAR_VALID,
  input  logic        CHAR_READY,
  output logic        FRAME_START,
  output logic        FRAME_DONE,
  output logic        BUSY
);

  typedef enum logic [2:0] {S_HOLD, S_ARM, S_LOAD, S_SEND, S_DONE} state_t;

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              pf_q;
  logic              rise;
  logic [23:0]       freq_q;
  logic [19:0]       max_q, min_q, mean_q, rms_q, vpp_q;
  logic [6:0]        idx, nxt_idx, pos;
  logic [7:0]        nxt_char, vlabel;
  logic [19:0]       vword;
  logic [3:0]        dig;
  logic              blank, is_dig;
  logic [5:1]        fblank;

  function automatic logic [7:0] enc(input logic [3:0] n);
    return (n > 4'd9) ? 8'h3F : {4'h3, n};
  endfunction

  assign rise = PERIOD_FLAG & ~pf_q;

  // A frequency digit is blanked only while it and every digit above it are zero.
  always_comb begin
    fblank[5] = (freq_q[23:20] == 4'h0);
    fblank[4] = fblank[5] & (freq_q[19:16] == 4'h0);
    fblank[3] = fblank[4] & (freq_q[15:12] == 4'h0);
    fblank[2] = fblank[3] & (freq_q[11:8]  == 4'h0);
    fblank[1] = fblank[2] & (freq_q[7:4]   == 4'h0);
  end

  // Character for the byte after the current one; registered on each transfer.
  always_comb begin
    nxt_idx  = idx + 7'd1;
    nxt_char = 8'h00;
    pos      = 7'd0;
    vword    = 20'h0;
    vlabel   = 8'h00;
    dig      = 4'h0;
    blank    = 1'b0;
    is_dig   = 1'b0;
    if (nxt_idx < 7'd12) begin
      case (nxt_idx)
        7'd1:    nxt_char = ":";
        7'd2:    begin dig = freq_q[23:20]; blank = fblank[5]; is_dig = 1'b1; end
        7'd3:    begin dig = freq_q[19:16]; blank = fblank[4]; is_dig = 1'b1; end
        7'd4:    begin dig = freq_q[15:12]; blank = fblank[3]; is_dig = 1'b1; end
        7'd5:    begin dig = freq_q[11:8];  blank = fblank[2]; is_dig = 1'b1; end
        7'd6:    begin dig = freq_q[7:4];   blank = fblank[1]; is_dig = 1'b1; end
        7'd7:    begin dig = freq_q[3:0];   is_dig = 1'b1; end
        7'd8:    nxt_char = "H";
        7'd9:    nxt_char = "z";
        7'd10:   nxt_char = 8'h0D;
        7'd11:   nxt_char = 8'h0A;
        default: nxt_char = "F";
      endcase
    end else begin
      if (nxt_idx < 7'd23) begin
        pos = nxt_idx - 7'd12; vword = max_q;  vlabel = "H";
      end else if (nxt_idx < 7'd34) begin
        pos = nxt_idx - 7'd23; vword = min_q;  vlabel = "L";
      end else if (nxt_idx < 7'd45) begin
        pos = nxt_idx - 7'd34; vword = mean_q; vlabel = "M";
      end else if (nxt_idx < 7'd56) begin
        pos = nxt_idx - 7'd45; vword = rms_q;  vlabel = "R";
      end else begin
        pos = nxt_idx - 7'd56; vword = vpp_q;  vlabel = "P";
      end
      case (pos)
        7'd0:    nxt_char = vlabel;
        7'd1:    nxt_char = ":";
        7'd2:    begin dig = vword[19:16]; is_dig = 1'b1; end
        7'd3:    nxt_char = ".";
        7'd4:    begin dig = vword[15:12]; is_dig = 1'b1; end
        7'd5:    begin dig = vword[11:8];  is_dig = 1'b1; end
        7'd6:    begin dig = vword[7:4];   is_dig = 1'b1; end
        7'd7:    begin dig = vword[3:0];   is_dig = 1'b1; end
        7'd8:    nxt_char = "V";
        7'd9:    nxt_char = 8'h0D;
        default: nxt_char = 8'h0A;
      endcase
    end
    if (is_dig) nxt_char = blank ? 8'h20 : enc(dig);
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state       <= S_HOLD;
      hold_cnt    <= '0;
      pf_q        <= 1'b0;
      freq_q      <= '0;
      max_q       <= '0;
      min_q       <= '0;
      mean_q      <= '0;
      rms_q       <= '0;
      vpp_q       <= '0;
      idx         <= '0;
      CHAR_DATA   <= 8'h00;
      CHAR_VALID  <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_DONE  <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      pf_q        <= PERIOD_FLAG;
      FRAME_START <= 1'b0;
      FRAME_DONE  <= 1'b0;
      unique case (state)
        S_HOLD: begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_W'(1);
          else if (RUN)             state    <= S_ARM;
        end
        S_ARM: begin
          if (!RUN) begin
            state <= S_HOLD;
          end else if (rise) begin
            state       <= S_LOAD;
            FRAME_START <= 1'b1;
            BUSY        <= 1'b1;
          end
        end
        S_LOAD: begin
          freq_q     <= frequency;
          max_q      <= max_t;
          min_q      <= min_t;
          mean_q     <= mean_t;
          rms_q      <= mean_t2;
          vpp_q      <= Vp2p_vol_t;
          idx        <= '0;
          CHAR_DATA  <= "F";
          CHAR_VALID <= 1'b1;
          state      <= S_SEND;
        end
        S_SEND: begin
          if (CHAR_READY) begin
            if (idx == 7'd66) begin
              CHAR_VALID <= 1'b0;
              CHAR_DATA  <= 8'h00;
              FRAME_DONE <= 1'b1;
              state      <= S_DONE;
            end else begin
              idx       <= nxt_idx;
              CHAR_DATA <= nxt_char;
            end
          end
        end
        S_DONE: begin
          BUSY     <= 1'b0;
          hold_cnt <= '0;
          state    <= S_HOLD;
        end
        default: state <= S_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_meas_text_serializer.sv
// Directed bench for meas_text_serializer: hand-written expected frames, latency,
// stall stability, reset abort, hold-off and RUN gating.
module tb_meas_text_serializer;

  logic        CLK = 1'b0;
  logic        RSTB, RUN, PERIOD_FLAG, CHAR_READY;
  logic [23:0] frequency;
  logic [19:0] max_t, min_t, mean_t, mean_t2, Vp2p_vol_t;
  logic [7:0]  CHAR_DATA;
  logic        CHAR_VALID, FRAME_START, FRAME_DONE, BUSY;

  int vectors = 0;
  int errs    = 0;

  meas_text_serializer #(.HOLD_CYCLES(8), .HOLD_W(4)) dut (
    .CLK(CLK), .RSTB(RSTB), .RUN(RUN), .PERIOD_FLAG(PERIOD_FLAG),
    .frequency(frequency), .max_t(max_t), .min_t(min_t), .mean_t(mean_t),
    .mean_t2(mean_t2), .Vp2p_vol_t(Vp2p_vol_t),
    .CHAR_DATA(CHAR_DATA), .CHAR_VALID(CHAR_VALID), .CHAR_READY(CHAR_READY),
    .FRAME_START(FRAME_START), .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic [23:0] f, input logic [19:0] h, input logic [19:0] l,
                        input logic [19:0] m, input logic [19:0] r, input logic [19:0] p);
    frequency = f; max_t = h; min_t = l; mean_t = m; mean_t2 = r; Vp2p_vol_t = p;
  endtask

  function automatic string frame(input string f, input string h, input string l,
                                  input string m, input string r, input string p);
    return {"F:", f, "Hz\r\n", "H:", h, "V\r\n", "L:", l, "V\r\n",
            "M:", m, "V\r\n", "R:", r, "V\r\n", "P:", p, "V\r\n"};
  endfunction

  // Must be called in ARM with PERIOD_FLAG low the previous cycle; returns in LOAD.
  task automatic start_frame;
    PERIOD_FLAG = 1'b1;
    tick;
    PERIOD_FLAG = 1'b0;
    chk("frame_start", FRAME_START, 1'b1);
    chk("busy_load", BUSY, 1'b1);
  endtask

  // Entered in LOAD; every valid cycle (stalled or not) must show the expected byte.
  task automatic recv_frame(input string exp, input bit stall, input int abort_at,
                            input int run_drop_at, input bit scramble, output int cyc);
    int n = 0;
    cyc = 0;
    while (n < 67 && cyc < 400) begin
      CHAR_READY = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (scramble && cyc == 3) begin
        set_in(24'h999999, 20'h11111, 20'h22222, 20'h33333, 20'h44444, 20'h55555);
        PERIOD_FLAG = 1'b1;
      end
      if (scramble && cyc == 4) PERIOD_FLAG = 1'b0;
      if (run_drop_at >= 0 && n == run_drop_at) RUN = 1'b0;
      if (abort_at >= 0 && n == abort_at && CHAR_VALID) begin
        RSTB = 1'b0;
        return;
      end
      if (CHAR_VALID) begin
        chk($sformatf("byte%0d", n), {24'h0, CHAR_DATA}, {24'h0, exp[n]});
        if (CHAR_READY) n++;
      end
      tick;
      cyc++;
    end
    if (abort_at >= 0) begin
      chk("abort_reached", n, abort_at);
    end else begin
      chk("frame_len", n, 67);
      chk("done_pulse", FRAME_DONE, 1'b1);
      chk("done_valid", CHAR_VALID, 1'b0);
      chk("done_busy", BUSY, 1'b1);
    end
  endtask

  string f1, f2, f3, f4, f5;
  int    cyc, first, busy_cnt;

  initial begin
    f1 = frame("  1234", "1.2345", "0.0000", "0.0000", "0.0000", "0.0000");
    f2 = frame("     0", "0.9999", "0.0001", "5.??03", "7.0710", "0.0000");
    f3 = frame(" ?0001", "3.3000", "0.0150", "0.1234", "9.8765", "3.2850");
    f4 = frame(" 50000", "2.5000", "1.0000", "1.7500", "1.8200", "1.5000");
    f5 = frame("999999", "1.1111", "2.2222", "3.3333", "4.4444", "5.5555");

    RSTB = 1'b1; RUN = 1'b1; PERIOD_FLAG = 1'b0; CHAR_READY = 1'b0;
    set_in(24'h0, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0);
    #2 RSTB = 1'b0;
    #10;
    chk("rst_data", CHAR_DATA, 8'h00);
    chk("rst_valid", CHAR_VALID, 1'b0);
    chk("rst_start", FRAME_START, 1'b0);
    chk("rst_done", FRAME_DONE, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    tick;
    RSTB = 1'b1;

    // Basic frame with leading-zero blanking and exact done latency.
    set_in(24'h001234, 20'h12345, 20'h0, 20'h0, 20'h0, 20'h0);
    repeat (12) tick;
    start_frame;
    recv_frame(f1, 1'b0, -1, -1, 1'b0, cyc);
    chk("done_latency", cyc, 68);

    // Reset at byte 20 aborts; a fresh frame then starts from 'F'.
    tick;
    repeat (12) tick;
    set_in(24'h000000, 20'h09999, 20'h00001, 20'h5AF03, 20'h70710, 20'h00000);
    start_frame;
    recv_frame(f2, 1'b0, 20, -1, 1'b0, cyc);
    tick;
    chk("abort_valid", CHAR_VALID, 1'b0);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_data", CHAR_DATA, 8'h00);
    RSTB = 1'b1;
    repeat (12) tick;
    start_frame;
    recv_frame(f2, 1'b0, -1, -1, 1'b0, cyc);
    chk("done_latency2", cyc, 68);

    // Ready pattern 1-0-0-1 throughout, '?' digit ends blanking.
    tick;
    repeat (12) tick;
    set_in(24'h0A0001, 20'h33000, 20'h00150, 20'h01234, 20'h98765, 20'h32850);
    start_frame;
    recv_frame(f3, 1'b1, -1, -1, 1'b0, cyc);

    // Inputs and a PERIOD_FLAG pulse change mid-frame; frame keeps LOAD-time values.
    tick;
    repeat (12) tick;
    set_in(24'h050000, 20'h25000, 20'h10000, 20'h17500, 20'h18200, 20'h15000);
    start_frame;
    recv_frame(f4, 1'b0, -1, -1, 1'b1, cyc);
    chk("done_latency4", cyc, 68);

    // Hold-off: pulses every 4th cycle; DONE=0, HOLD 1..8, ARM 9.., rise at 12 -> LOAD at 13.
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      PERIOD_FLAG = (k % 4 == 0);
      if (FRAME_START) begin
        first = k;
        break;
      end
    end
    PERIOD_FLAG = 1'b0;
    chk("holdoff_start", first, 13);
    recv_frame(f5, 1'b0, -1, -1, 1'b0, cyc);
    chk("done_latency5", cyc, 68);

    // RUN dropped at byte 30: frame completes, then stays idle until RUN returns.
    repeat (12) tick;
    set_in(24'h001234, 20'h12345, 20'h0, 20'h0, 20'h0, 20'h0);
    start_frame;
    recv_frame(f1, 1'b0, -1, 30, 1'b0, cyc);
    busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      tick;
      PERIOD_FLAG = k[0];
      if (BUSY || FRAME_START) busy_cnt++;
    end
    chk("idle_busy", busy_cnt, 0);
    PERIOD_FLAG = 1'b0;
    RUN = 1'b1;
    tick;
    tick;
    chk("rearm_no_start", FRAME_START, 1'b0);
    start_frame;
    recv_frame(f1, 1'b0, -1, -1, 1'b0, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
